// File: rtl/counter_pkg.sv
// Shared types for the counter command sequencer:
// command op-codes and sequencer FSM states.
package counter_pkg;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'b00,
        OP_LOAD  = 2'b01,
        OP_UP    = 2'b10,
        OP_DOWN  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_PULSE = 2'b01,
        S_STEP  = 2'b10,
        S_DONE  = 2'b11
    } state_e;

    function automatic logic is_step(input op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/counter_cmd_seq.sv
// Turns CLEAR/LOAD/UP/DOWN commands into control pulses for a
// loadable up/down counter and tracks its expected value.
module counter_cmd_seq
    import counter_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [N-1:0] cmd_arg,
    input  logic         stall,
    output logic         ctl_syn_clr,
    output logic         ctl_load,
    output logic         ctl_en,
    output logic         ctl_up,
    output logic [N-1:0] ctl_d,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] shadow_q,
    output logic         wrap
);

    state_e       r_state;
    op_e          r_op;
    logic [N-1:0] r_cnt;
    logic [N-1:0] r_d;
    logic [N-1:0] r_shadow;
    logic         r_wrap;

    op_e  w_op;
    logic w_accept;

    assign w_op     = op_e'(cmd_op);
    assign w_accept = cmd_valid && cmd_ready;

    // Control bus comes only from registered state and stall.
    always_comb begin
        cmd_ready   = 1'b0;
        ctl_syn_clr = 1'b0;
        ctl_load    = 1'b0;
        ctl_en      = 1'b0;
        ctl_up      = 1'b0;
        ctl_d       = '0;
        if (!rst) begin
            cmd_ready   = (r_state == S_IDLE);
            ctl_syn_clr = (r_state == S_PULSE) && (r_op == OP_CLEAR);
            ctl_load    = (r_state == S_PULSE) && (r_op == OP_LOAD);
            ctl_en      = (r_state == S_STEP) && !stall;
            ctl_up      = (r_state == S_STEP) && (r_op == OP_UP);
            ctl_d       = r_d;
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign shadow_q = r_shadow;
    assign wrap     = r_wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_op    <= OP_CLEAR;
            r_cnt   <= '0;
            r_d     <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op <= w_op;
                        if (is_step(w_op)) begin
                            r_cnt   <= cmd_arg;
                            r_state <= (cmd_arg == '0) ? S_DONE : S_STEP;
                        end else begin
                            r_state <= S_PULSE;
                            if (w_op == OP_LOAD)
                                r_d <= cmd_arg;
                        end
                    end
                end
                S_PULSE: r_state <= S_DONE;
                S_STEP: begin
                    if (!stall) begin
                        r_cnt <= r_cnt - N'(1);
                        if (r_cnt == N'(1))
                            r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Shadow follows the control cycle one clock later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= '0;
            r_wrap   <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            unique case (1'b1)
                ctl_syn_clr: r_shadow <= '0;
                ctl_load:    r_shadow <= r_d;
                ctl_en: begin
                    if (ctl_up) begin
                        r_shadow <= r_shadow + N'(1);
                        r_wrap   <= &r_shadow;
                    end else begin
                        r_shadow <= r_shadow - N'(1);
                        r_wrap   <= ~|r_shadow;
                    end
                end
                default: r_shadow <= r_shadow;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Scoreboard bench for counter_cmd_seq: stimulus queues expected
// control/done/wrap events, a monitor matches them per cycle.
module tb_counter_cmd_seq;
    import counter_pkg::*;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'b00;
    logic [N-1:0] cmd_arg = '0;
    logic         stall = 1'b0;
    logic         ctl_syn_clr, ctl_load, ctl_en, ctl_up;
    logic [N-1:0] ctl_d;
    logic         busy, done, wrap;
    logic [N-1:0] shadow_q;

    counter_cmd_seq #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .stall(stall),
        .ctl_syn_clr(ctl_syn_clr), .ctl_load(ctl_load),
        .ctl_en(ctl_en), .ctl_up(ctl_up), .ctl_d(ctl_d),
        .busy(busy), .done(done),
        .shadow_q(shadow_q), .wrap(wrap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] c;
        logic        clr, ld, en, up;
        logic [7:0]  d;
        logic        dn, wr;
        logic [7:0]  sh;
    } ev_t;

    ev_t expq[$];
    int  total  = 0;
    int  passed = 0;
    int  cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] req);
        total++;
        if (got === req) passed++;
        else $display("FAIL %s got=%h required=%h", nm, got, req);
    endtask

    task automatic ex(input int c, input logic clr, ld, en, up,
                      input logic [7:0] d, input logic dn, wr,
                      input logic [7:0] sh);
        expq.push_back({c[31:0], clr, ld, en, up, d, dn, wr, sh});
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] arg,
                         output int t);
        int k;
        k = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(negedge clk);
        while (!cmd_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("accept", {31'd0, cmd_ready}, 32'd1);
        t = cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        ev_t g, e;
        forever begin
            @(negedge clk);
            if (ctl_syn_clr | ctl_load | ctl_en | done | wrap) begin
                g = {cyc[31:0], ctl_syn_clr, ctl_load, ctl_en, ctl_up,
                     ctl_d, done, wrap, shadow_q};
                total++;
                if (expq.size() == 0) begin
                    $display("FAIL unexpected_event cyc=%0d got=%h", cyc, g);
                end else begin
                    e = expq.pop_front();
                    if (g === e) passed++;
                    else $display("FAIL event cyc=%0d got=%h required=%h",
                                  cyc, g, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int t, t1, t2;
        rst = 1'b1;
        goto(3);
        @(negedge clk);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_ctl", {20'd0, ctl_syn_clr, ctl_load, ctl_en, ctl_up, ctl_d},
            32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("post_rst_status", {29'd0, busy, done, wrap}, 32'd0);
        chk("post_rst_shadow", {24'd0, shadow_q}, 32'd0);
        chk("post_rst_ctl_d", {24'd0, ctl_d}, 32'd0);
        @(posedge clk);
        #1;

        issue(OP_LOAD, 8'hA5, t);
        ex(t+1, 0, 1, 0, 0, 8'hA5, 0, 0, 8'h00);
        ex(t+2, 0, 0, 0, 0, 8'hA5, 1, 0, 8'hA5);

        issue(OP_LOAD, 8'hFE, t);
        ex(t+1, 0, 1, 0, 0, 8'hFE, 0, 0, 8'hA5);
        ex(t+2, 0, 0, 0, 0, 8'hFE, 1, 0, 8'hFE);

        issue(OP_UP, 8'd3, t);
        cmd_valid = 1'b0;
        ex(t+1, 0, 0, 1, 1, 8'hFE, 0, 0, 8'hFE);
        ex(t+2, 0, 0, 1, 1, 8'hFE, 0, 0, 8'hFF);
        ex(t+3, 0, 0, 1, 1, 8'hFE, 0, 1, 8'h00);
        ex(t+4, 0, 0, 0, 0, 8'hFE, 1, 0, 8'h01);
        goto(t+5);

        issue(OP_DOWN, 8'd4, t);
        cmd_valid = 1'b0;
        ex(t+1, 0, 0, 1, 0, 8'hFE, 0, 0, 8'h01);
        ex(t+2, 0, 0, 1, 0, 8'hFE, 0, 0, 8'h00);
        ex(t+3, 0, 0, 0, 0, 8'hFE, 0, 1, 8'hFF);
        ex(t+5, 0, 0, 1, 0, 8'hFE, 0, 0, 8'hFF);
        ex(t+6, 0, 0, 1, 0, 8'hFE, 0, 0, 8'hFE);
        ex(t+7, 0, 0, 0, 0, 8'hFE, 1, 0, 8'hFD);
        goto(t+3);
        stall = 1'b1;
        goto(t+4);
        @(negedge clk);
        chk("stall_en", {31'd0, ctl_en}, 32'd0);
        chk("stall_shadow", {24'd0, shadow_q}, 32'hFF);
        goto(t+5);
        stall = 1'b0;
        goto(t+8);

        issue(OP_UP, 8'd0, t);
        cmd_valid = 1'b0;
        ex(t+1, 0, 0, 0, 0, 8'hFE, 1, 0, 8'hFD);
        goto(t+3);

        issue(OP_UP, 8'd10, t);
        cmd_valid = 1'b0;
        ex(t+1, 0, 0, 1, 1, 8'hFE, 0, 0, 8'hFD);
        ex(t+2, 0, 0, 1, 1, 8'hFE, 0, 0, 8'hFE);
        ex(t+3, 0, 0, 1, 1, 8'hFE, 0, 0, 8'hFF);
        ex(t+4, 0, 0, 1, 1, 8'hFE, 0, 1, 8'h00);
        ex(t+5, 0, 0, 1, 1, 8'hFE, 0, 0, 8'h01);
        goto(t+6);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd0);
        goto(t+7);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_en", {31'd0, ctl_en}, 32'd0);
        chk("abort_shadow", {24'd0, shadow_q}, 32'd0);
        chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
        chk("abort_ctl_d", {24'd0, ctl_d}, 32'd0);
        goto(t+14);

        issue(OP_LOAD, 8'h77, t);
        ex(t+1, 0, 1, 0, 0, 8'h77, 0, 0, 8'h00);
        ex(t+2, 0, 0, 0, 0, 8'h77, 1, 0, 8'h77);

        issue(OP_CLEAR, 8'h00, t1);
        ex(t1+1, 1, 0, 0, 0, 8'h77, 0, 0, 8'h77);
        ex(t1+2, 0, 0, 0, 0, 8'h77, 1, 0, 8'h00);

        issue(OP_LOAD, 8'h3C, t2);
        cmd_valid = 1'b0;
        chk("b2b_accept_cycle", t2, t1 + 3);
        ex(t2+1, 0, 1, 0, 0, 8'h3C, 0, 0, 8'h00);
        ex(t2+2, 0, 0, 0, 0, 8'h3C, 1, 0, 8'h3C);
        goto(t2+6);

        chk("queue_drained", expq.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
